keypad_scan_debounce: RTL
=========================

# keypad_scan_debounce

Scans the 4x4 matrix keypad, debounces every key, and produces the clean paddle commands (up1, down1, up2, down2) plus a key-press event stream. It sits directly upstream of the paddle/ball state machine and the top-level game FSM. It runs on the system clock with an internal scan prescaler, so no divided clock is needed.

## Interface
- SCAN_DIV, default 50000: system-clock cycles per row dwell; minimum 2.
- DEB_SCANS, default 3: consecutive full scans with an unchanged raw level required before a key's debounced state flips; minimum 1.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- kp_col  in  4  keypad columns, active-low (pulled up; 0 = key closed on the driven row).
- kp_row  out  4  row drive, active-low, one-hot-zero.
- up1 / down1 / up2 / down2  out  1 each  debounced paddle commands, level, high while held.
- key_down  out  16  debounced state of every key; bit index = row*4 + col.
- press_pulse  out  1  one-cycle strobe on any key going released->pressed.
- key_code  out  4  index of the most recent pressed key; updates with press_pulse.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. Its terminal count is the scan tick.
- A 2-bit row pointer advances on each scan tick (0->1->2->3->0).
- kp_row = ~(4'b0001 << row_ptr).
- Columns are sampled when prescaler = SCAN_DIV-2. This is the last full cycle of the dwell and allows settling. The raw level for the 4 keys of the current row is ~kp_col.
- Per-key counter, width clog2(DEB_SCANS+1), updated only on that key's sample:
  - raw == key_down[i]: counter cleared.
  - Otherwise counter increments.
  - When the increment reaches DEB_SCANS, key_down[i] toggles and the counter clears.
- Key map: up1 = key 0 (r0,c0), down1 = key 4 (r1,c0), up2 = key 3 (r0,c3), down2 = key 7 (r1,c3).
- Simultaneous rise on several keys of one sampled row: a single press_pulse; key_code = lowest column index among them.
- Release transitions produce no pulse and leave key_code unchanged.
- Reset mid-operation clears everything immediately (asynchronous), including partial debounce counts.

## Timing
- Reset values:
  - kp_row = 4'b1110; row_ptr = 0; prescaler = 0.
  - key_down = 0; all counters = 0.
  - up1/down1/up2/down2 = 0; press_pulse = 0; key_code = 0.
- One full scan = 4*SCAN_DIV cycles. Each key is sampled once per scan.
- Press latency from stable closure: key_down set at the DEB_SCANS-th qualifying sample. Worst case (DEB_SCANS+1)*4*SCAN_DIV cycles. Release latency is identical.
- A single opposite sample interrupting a run restarts the count (glitch rejection).
- key_down, press_pulse and key_code are registered and change on the clock edge after the qualifying sample.
- Paddle outputs are combinational from key_down and registers; they add no cycle of latency.
- press_pulse is high for exactly one clk cycle.

## Configuration
- KP_CONFLICT_MASK_EN defined: when up and down of the same player are both debounced-pressed, both of that player's outputs are forced to 0. The other player is unaffected.
- KP_CONFLICT_MASK_EN undefined: paddle outputs mirror key_down bits 0/4/3/7 directly, so up1 and down1 may both be 1.
- key_down, press_pulse and key_code are identical in both builds.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_SCANS=3 (scan = 16 cycles).

- Reset, kp_col=4'hF: kp_row cycles 1110, 1101, 1011, 0111, each for 4 cycles, then repeats. All outputs stay 0.
- Hold key 0 closed (kp_col[0]=0 while kp_row[0]=0): up1 and key_down[0] rise at the 3rd sample, within 64 cycles. press_pulse is high for 1 cycle with key_code=0. Release: up1 falls 3 scans later with no pulse.
- Key 7 bounce, closed for scans 1-2, open for scan 3, then closed: no rise until 3 consecutive closed samples after the reopen. down2 stays 0 throughout the bounce.
- Keys 0 and 4 both held:
  - Mask build: up1 = down1 = 0, key_down[4] = key_down[0] = 1.
  - Unmasked build: up1 = down1 = 1.
- Keys 1 and 2 closed together on row 0: key_down[1] and key_down[2] rise on the same edge, one press_pulse, key_code = 1.
- Assert rst low while key 3 is at count 2: all counters and key_down clear at once. After release of reset, 3 fresh samples are needed before up2 = 1.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: scans a 4x4 active-low matrix keypad and debounces all 16 keys.
// Latency: key_down/press_pulse/key_code update on the edge after a key's qualifying sample; paddle outputs add none.
// Backpressure: none; the scan free-runs and press_pulse is a one-cycle strobe with no handshake.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   kp_col[3:0]       keypad columns, active-low (0 = key closed on the driven row)
//   kp_row[3:0]       row drive, active-low, exactly one row low at a time
//   up1/down1/up2/down2  debounced paddle commands (level, high while held)
//   key_down[15:0]    debounced state of every key, bit index = row*4 + col
//   press_pulse       one-cycle strobe on any released->pressed transition
//   key_code[3:0]     index of the most recently pressed key
//
// Build option: define KP_CONFLICT_MASK_EN to force both paddle outputs of a
// player to 0 while that player's up and down keys are both pressed.
module keypad_scan_debounce #(
   parameter int SCAN_DIV  = 50000,  // clk cycles per row dwell, >= 2
   parameter int DEB_SCANS = 3       // consecutive opposite samples needed to flip, >= 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  kp_col,
   output logic [3:0]  kp_row,
   output logic        up1,
   output logic        down1,
   output logic        up2,
   output logic        down2,
   output logic [15:0] key_down,
   output logic        press_pulse,
   output logic [3:0]  key_code
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEB_SCANS + 1);

   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   // Sampling one cycle before the row switches gives the column lines the
   // whole dwell minus one cycle to settle after the row drive changed.
   localparam logic [PW-1:0] PRE_SAMP = PW'(SCAN_DIV - 2);
   localparam logic [CW:0]   DEB_TGT  = (CW + 1)'(DEB_SCANS);

   // ---------------------------------------------------------------------
   // Scan prescaler and row pointer
   // ---------------------------------------------------------------------
   logic [PW-1:0] presc;
   logic [1:0]    row_ptr;
   logic          scan_tick;
   logic          sample_en;

   assign scan_tick = (presc == PRE_LAST);
   assign sample_en = (presc == PRE_SAMP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         row_ptr <= '0;
      end else begin
         if (scan_tick) begin
            presc   <= '0;
            row_ptr <= row_ptr + 2'd1;
         end else begin
            presc   <= presc + 1'b1;
         end
      end
   end

   assign kp_row = ~(4'b0001 << row_ptr);

   // ---------------------------------------------------------------------
   // Debounce: only the four keys of the currently driven row are touched
   // on a sample; all other keys hold their counters.
   // ---------------------------------------------------------------------
   logic [CW-1:0] cnt     [16];
   logic [CW-1:0] cnt_nxt [16];
   logic [15:0]   kd_nxt;
   logic [3:0]    raw;
   logic [3:0]    rise;
   logic [1:0]    rise_col;

   assign raw = ~kp_col;

   always_comb begin
      kd_nxt   = key_down;
      cnt_nxt  = cnt;
      rise     = '0;
      rise_col = '0;
      if (sample_en) begin
         for (int c = 0; c < 4; c++) begin
            if (raw[c] == key_down[{row_ptr, 2'(c)}]) begin
               // Agreement with the debounced level breaks any run in progress.
               cnt_nxt[{row_ptr, 2'(c)}] = '0;
            end else if (({1'b0, cnt[{row_ptr, 2'(c)}]} + 1'b1) == DEB_TGT) begin
               kd_nxt[{row_ptr, 2'(c)}]  = raw[c];
               cnt_nxt[{row_ptr, 2'(c)}] = '0;
               rise[c]                   = raw[c];
            end else begin
               cnt_nxt[{row_ptr, 2'(c)}] = cnt[{row_ptr, 2'(c)}] + 1'b1;
            end
         end
      end
      // Several keys of one row may rise together; report the lowest column.
      for (int c = 3; c >= 0; c--) begin
         if (rise[c]) begin
            rise_col = 2'(c);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_down <= '0;
         cnt      <= '{default: '0};
      end else begin
         key_down <= kd_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Press event stream; releases neither pulse nor move key_code.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_pulse <= 1'b0;
         key_code    <= '0;
      end else begin
         press_pulse <= |rise;
         if (|rise) begin
            key_code <= {row_ptr, rise_col};
         end
      end
   end

   // ---------------------------------------------------------------------
   // Paddle commands
   // ---------------------------------------------------------------------
`ifdef KP_CONFLICT_MASK_EN
   // Up and down held together cancel each other for that player only.
   logic conflict1;
   logic conflict2;

   assign conflict1 = key_down[0] & key_down[4];
   assign conflict2 = key_down[3] & key_down[7];
   assign up1       = key_down[0] & ~conflict1;
   assign down1     = key_down[4] & ~conflict1;
   assign up2       = key_down[3] & ~conflict2;
   assign down2     = key_down[7] & ~conflict2;
`else
   assign up1   = key_down[0];
   assign down1 = key_down[4];
   assign up2   = key_down[3];
   assign down2 = key_down[7];
`endif

endmodule
